// File: rtl/ins_exec_rv32i_s_st.sv
// RV32I store executor: computes the effective address, lane-aligns SB/SH/SW data
// and drives one request/acknowledge write onto the data-memory port.
module ins_exec_rv32i_s_st (
  input  logic        clk,
  input  logic        rst,
  input  logic        op,
  input  logic [6:0]  ins_dec_op,
  input  logic [2:0]  ins_dec_funct3,
  input  logic [11:0] ins_dec_imm,
  input  logic [31:0] reg_rs1_val,
  input  logic [31:0] reg_rs2_val,
  output logic        mem_w_req,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_be,
  input  logic        mem_w_ack,
  output logic        busy,
  output logic        done,
  output logic        exc_misaligned,
  output logic        exc_illegal
);

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] ea;
  logic        funct3_legal;
  logic        misaligned;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;

  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [3:0]  be_reg;
  logic        err_illegal_reg;

  assign ea = reg_rs1_val + {{20{ins_dec_imm[11]}}, ins_dec_imm};

  always_comb begin
    funct3_legal = 1'b0;
    misaligned   = 1'b0;
    lane_data    = 32'd0;
    lane_be      = 4'b0000;
    case (ins_dec_funct3)
      F3_SB: begin
        funct3_legal = 1'b1;
        lane_data    = {4{reg_rs2_val[7:0]}};
        lane_be      = 4'b0001 << ea[1:0];
      end
      F3_SH: begin
        funct3_legal = 1'b1;
        misaligned   = ea[0];
        lane_data    = {2{reg_rs2_val[15:0]}};
        lane_be      = ea[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW: begin
        funct3_legal = 1'b1;
        misaligned   = (ea[1:0] != 2'b00);
        lane_data    = reg_rs2_val;
        lane_be      = 4'b1111;
      end
      default: begin
        funct3_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (op && (ins_dec_op == OPC_STORE)) begin
          if (!funct3_legal || misaligned) state_next = ERR;
          else                             state_next = REQ;
        end
      end
      REQ:     if (mem_w_ack) state_next = FIN;
      FIN:     state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Write beats are latched at acceptance so input churn cannot disturb an open request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg        <= 32'd0;
      data_reg        <= 32'd0;
      be_reg          <= 4'b0000;
      err_illegal_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && state_next == REQ) begin
        addr_reg <= {ea[31:2], 2'b00};
        data_reg <= lane_data;
        be_reg   <= lane_be;
      end else if (state_reg == REQ && state_next != REQ) begin
        be_reg <= 4'b0000;
      end
      if (state_reg == IDLE && state_next == ERR)
        err_illegal_reg <= !funct3_legal;
    end
  end

  assign mem_w_req      = (state_reg == REQ);
  assign mem_w_addr     = addr_reg;
  assign mem_w_data     = data_reg;
  assign mem_w_be       = be_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == FIN);
  assign exc_illegal    = (state_reg == ERR) && err_illegal_reg;
  assign exc_misaligned = (state_reg == ERR) && !err_illegal_reg;

endmodule

// File: tb/tb_ins_exec_rv32i_s_st.sv
// Directed bench for the RV32I store executor: vector table plus handshake,
// busy-ignore and reset-during-request sequences.
module tb_ins_exec_rv32i_s_st;

  logic        clk;
  logic        rst;
  logic        op;
  logic [6:0]  ins_dec_op;
  logic [2:0]  ins_dec_funct3;
  logic [11:0] ins_dec_imm;
  logic [31:0] reg_rs1_val;
  logic [31:0] reg_rs2_val;
  logic        mem_w_req;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_w_be;
  logic        mem_w_ack;
  logic        busy;
  logic        done;
  logic        exc_misaligned;
  logic        exc_illegal;

  int checks;
  int failures;

  ins_exec_rv32i_s_st dut (
    .clk(clk), .rst(rst), .op(op), .ins_dec_op(ins_dec_op),
    .ins_dec_funct3(ins_dec_funct3), .ins_dec_imm(ins_dec_imm),
    .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
    .mem_w_req(mem_w_req), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_be(mem_w_be), .mem_w_ack(mem_w_ack), .busy(busy), .done(done),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = performed, 1 = misaligned, 2 = illegal funct3
  typedef struct {
    string       name;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          kind;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".req"},  {31'd0, mem_w_req}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".exc_mis"}, {31'd0, exc_misaligned}, 32'd0);
    check({tag, ".exc_ill"}, {31'd0, exc_illegal}, 32'd0);
    check({tag, ".be"},   {28'd0, mem_w_be}, 32'd0);
  endtask

  // Called at a negedge; leaves the bench at the negedge of cycle N+1.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [11:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    op = 1'b1; ins_dec_op = opc; ins_dec_funct3 = f3; ins_dec_imm = imm;
    reg_rs1_val = rs1; reg_rs2_val = rs2;
    @(posedge clk);
    @(negedge clk);
    op = 1'b0;
    reg_rs1_val = 32'h5555_5555; reg_rs2_val = 32'hAAAA_AAAA; ins_dec_imm = 12'h333;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; op = 1'b0; mem_w_ack = 1'b0;
    ins_dec_op = 7'd0; ins_dec_funct3 = 3'd0; ins_dec_imm = 12'd0;
    reg_rs1_val = 32'd0; reg_rs2_val = 32'd0;

    vecs[0] = '{"sw_basic",   3'd2, 12'h004, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111};
    vecs[1] = '{"sb_lane3",   3'd0, 12'h000, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000};
    vecs[2] = '{"sb_neg_imm", 3'd0, 12'hFFD, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0001};
    vecs[3] = '{"sh_mis",     3'd1, 12'h000, 32'h0000_3001, 32'h0000_1111, 1, 32'h0, 32'h0, 4'b0000};
    vecs[4] = '{"sw_mis",     3'd2, 12'h000, 32'h0000_3002, 32'h2222_2222, 1, 32'h0, 32'h0, 4'b0000};
    vecs[5] = '{"f3_illegal", 3'd3, 12'h000, 32'h0000_3001, 32'h3333_3333, 2, 32'h0, 32'h0, 4'b0000};
    vecs[6] = '{"sb_wrap",    3'd0, 12'h001, 32'hFFFF_FFFF, 32'h1234_5677, 0, 32'h0000_0000, 32'h7777_7777, 4'b0001};
    vecs[7] = '{"sh_upper",   3'd1, 12'hFFE, 32'h0000_0020, 32'h0000_ABCD, 0, 32'h0000_001C, 32'hABCD_ABCD, 4'b1100};
    vecs[8] = '{"sw_imm_max", 3'd2, 12'h7FC, 32'h0000_0008, 32'h0BAD_F00D, 0, 32'h0000_0804, 32'h0BAD_F00D, 4'b1111};

    // Reset state
    #2;
    check_idle_outputs("reset");
    check("reset.addr", mem_w_addr, 32'd0);
    check("reset.data", mem_w_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Table vectors with ack held high
    mem_w_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(7'b0100011, vecs[i].funct3, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      if (vecs[i].kind == 0) begin
        check({vecs[i].name, ".req"},  {31'd0, mem_w_req}, 32'd1);
        check({vecs[i].name, ".busy"}, {31'd0, busy}, 32'd1);
        check({vecs[i].name, ".addr"}, mem_w_addr, vecs[i].exp_addr);
        check({vecs[i].name, ".data"}, mem_w_data, vecs[i].exp_data);
        check({vecs[i].name, ".be"},   {28'd0, mem_w_be}, {28'd0, vecs[i].exp_be});
        @(negedge clk);
        check({vecs[i].name, ".done"}, {31'd0, done}, 32'd1);
        check({vecs[i].name, ".req_fin"}, {31'd0, mem_w_req}, 32'd0);
        check({vecs[i].name, ".be_fin"}, {28'd0, mem_w_be}, 32'd0);
      end else begin
        check({vecs[i].name, ".exc_mis"}, {31'd0, exc_misaligned}, (vecs[i].kind == 1) ? 32'd1 : 32'd0);
        check({vecs[i].name, ".exc_ill"}, {31'd0, exc_illegal}, (vecs[i].kind == 2) ? 32'd1 : 32'd0);
        check({vecs[i].name, ".req"},  {31'd0, mem_w_req}, 32'd0);
        check({vecs[i].name, ".be"},   {28'd0, mem_w_be}, 32'd0);
        check({vecs[i].name, ".busy"}, {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      check_idle_outputs({vecs[i].name, ".after"});
      $display("vector %s kind=%0d addr=0x%08h be=%b", vecs[i].name, vecs[i].kind, mem_w_addr, mem_w_be);
    end

    // Non-store opcode must be ignored
    issue(7'b0000011, 3'd2, 12'h0, 32'h100, 32'h1);
    check("load_opc.busy", {31'd0, busy}, 32'd0);
    check("load_opc.req", {31'd0, mem_w_req}, 32'd0);
    $display("sequence non_store_opcode busy=%b", busy);

    // SH with ack delayed: request held five cycles, op during busy ignored
    mem_w_ack = 1'b0;
    issue(7'b0100011, 3'd1, 12'h002, 32'h0000_0010, 32'h0000_1234);
    op = 1'b1; ins_dec_funct3 = 3'd2; ins_dec_imm = 12'h0; reg_rs1_val = 32'h40; reg_rs2_val = 32'h99;
    for (int c = 0; c < 5; c++) begin
      check("sh_wait.req",  {31'd0, mem_w_req}, 32'd1);
      check("sh_wait.addr", mem_w_addr, 32'h0000_0010);
      check("sh_wait.be",   {28'd0, mem_w_be}, 32'b1100);
      check("sh_wait.data", mem_w_data, 32'h1234_1234);
      if (c == 4) mem_w_ack = 1'b1;
      @(negedge clk);
    end
    mem_w_ack = 1'b0;
    op = 1'b0;
    check("sh_wait.done", {31'd0, done}, 32'd1);
    check("sh_wait.req_fin", {31'd0, mem_w_req}, 32'd0);
    @(negedge clk);
    check_idle_outputs("sh_wait.idle");
    @(negedge clk);
    check("sh_wait.no_second_req", {31'd0, mem_w_req | busy}, 32'd0);
    $display("sequence sh_delayed_ack addr=0x%08h data=0x%08h", mem_w_addr, mem_w_data);

    // Reset asserted while in REQ
    issue(7'b0100011, 3'd2, 12'h000, 32'h0000_0100, 32'hCAFE_F00D);
    check("rst_req.req_before", {31'd0, mem_w_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("rst_req");
    check("rst_req.addr", mem_w_addr, 32'd0);
    check("rst_req.data", mem_w_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    mem_w_ack = 1'b1;
    issue(7'b0100011, 3'd2, 12'h008, 32'h0000_0200, 32'h0102_0304);
    check("post_rst.req",  {31'd0, mem_w_req}, 32'd1);
    check("post_rst.addr", mem_w_addr, 32'h0000_0208);
    check("post_rst.data", mem_w_data, 32'h0102_0304);
    check("post_rst.be",   {28'd0, mem_w_be}, 32'b1111);
    @(negedge clk);
    check("post_rst.done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_idle_outputs("post_rst.idle");
    $display("sequence reset_during_req addr=0x%08h", mem_w_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ins_exec_rv32i_s_st.md
# ins_exec_rv32i_s_st

Executes RV32I store instructions (SB/SH/SW, opcode 7'b0100011) and drives them onto the data-memory write port with a request/acknowledge handshake. It is the write-side counterpart of the load executor: that unit moves memory data into a register, and this one moves register data into memory. It sits in the execute stage beside the other `InsExec_RV32I_*` units and takes decoded fields and register-file read values. It reports completion, misalignment and illegal-funct3 events to the core control.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  1  execute strobe; sampled only in IDLE.
- `ins_dec_op`  in  7  decoded opcode; the unit acts only on 7'b0100011.
- `ins_dec_funct3`  in  3  0=SB, 1=SH, 2=SW; any other value is illegal.
- `ins_dec_imm`  in  12  S-type immediate, signed.
- `reg_rs1_val`  in  32  base address register value.
- `reg_rs2_val`  in  32  store data register value.
- `mem_w_req`  out  1  write request, held until acknowledged.
- `mem_w_addr`  out  32  word-aligned address, {ea[31:2],2'b00}.
- `mem_w_data`  out  32  lane-replicated write data.
- `mem_w_be`  out  4  byte enables; bit n enables byte lane n.
- `mem_w_ack`  in  1  memory accepted the write.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `exc_misaligned`  out  1  one-cycle pulse; the store was not performed.
- `exc_illegal`  out  1  one-cycle pulse for illegal funct3; the store was not performed.

## Operation
- Effective address: ea = reg_rs1_val + sign_extend(ins_dec_imm). The addition is modulo 2^32, so 0xFFFFFFFF + 1 wraps to 0.
- SB: data = {4{rs2[7:0]}}; be = 4'b0001 << ea[1:0]. Any alignment is accepted.
- SH: data = {2{rs2[15:0]}}; be = ea[1] ? 4'b1100 : 4'b0011. A store with ea[0]=1 is misaligned.
- SW: data = rs2; be = 4'b1111. A store with ea[1:0] != 0 is misaligned.
- Address, data and byte enables are computed and registered in the cycle `op` is accepted. Later changes on the inputs have no effect until the unit returns to IDLE.
- FSM states: IDLE, REQ, FIN, ERR.
  - IDLE→REQ: op=1, opcode matches, funct3 legal, address aligned.
  - IDLE→ERR: op=1, opcode matches, and either funct3 is illegal or the address is misaligned. Illegal funct3 takes priority: if both hold, only `exc_illegal` pulses.
  - IDLE stays IDLE: op=0, or the opcode does not match.
  - REQ→FIN: mem_w_ack=1 sampled at a clock edge. Otherwise REQ holds.
  - FIN→IDLE and ERR→IDLE: unconditional after one cycle.
- `done` is high only in FIN. `exc_*` is high only in ERR.
- `op` is ignored while busy. There is no queueing; the core must re-issue the instruction.
- `mem_w_ack` is ignored outside REQ.
- Register-file write outputs are not provided; stores never write rd.

## Timing
- Reset values, applied asynchronously: state=IDLE; mem_w_req=0; mem_w_addr=0; mem_w_data=0; mem_w_be=0; busy=0; done=0; exc_misaligned=0; exc_illegal=0.
- Assertion of `rst` during REQ drops `mem_w_req` immediately, and the write is abandoned.
- Cycle N: op accepted.
- Cycle N+1: mem_w_req=1, busy=1. addr/data/be are valid and stay stable while req=1.
- Ack sampled at edge E: mem_w_req=0 and done=1 in the cycle after E. IDLE follows one cycle later, and a new op is accepted in that IDLE cycle.
- Minimum occupancy is 3 cycles when ack is tied high (REQ, FIN, then IDLE).
- Error path: the exception pulse appears in cycle N+1, and a new op is accepted in N+2.
- Outside REQ, mem_w_addr, mem_w_data and mem_w_be hold their last values. mem_w_be is cleared to 0 on leaving REQ, so be≠0 only while req=1.

## Test plan
- SW with ack held high: rs1=0x1000, imm=0x004, rs2=0xDEADBEEF. Required: req in N+1, addr=0x1004, be=1111, data=0xDEADBEEF, done in N+2.
- SB lanes: rs1=0x2003, imm=0, rs2=0x000000A5. Required: addr=0x2000, be=1000, data=0xA5A5A5A5. Repeat with imm=-3 (0xFFD). Required: addr=0x2000, be=0001.
- SH with ack delayed 4 cycles: rs1=0x10, imm=2, rs2=0x1234. Required: req held 5 cycles with stable addr=0x10, be=1100, data=0x12341234. Also drive op=1 during busy; it must be ignored (no second request).
- Misaligned SH at ea=0x3001 and SW at ea=0x3002. Required: exc_misaligned pulse in N+1, req never asserts.
- funct3=3 with ea misaligned. Required: exc_illegal=1 and exc_misaligned=0. Also wrap case: rs1=0xFFFFFFFF, imm=1, SB. Required: addr=0, be=0001.
- Assert rst while in REQ. Required: req=0 in the same cycle and all outputs at reset values. After release, a new SW completes normally.
